// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a single-outstanding-request instruction memory,
// buffers a returned word across IF/ID stalls, and squashes responses after a redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_4
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic [31:0] hold_reg;
  logic [31:0] pend_reg;
  logic [31:0] target;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_addr = pc_reg;
  assign pc_plus_4 = pc_reg + 32'd4;
  assign imem_req  = !rst && (state_reg != ST_HOLD);
  assign inst      = (state_reg == ST_HOLD) ? hold_reg : imem_rdata;

  always_comb begin
    inst_valid = 1'b0;
    if (!rst && !redirect) begin
      if (state_reg == ST_HOLD)
        inst_valid = 1'b1;
      else if (state_reg == ST_REQ && imem_ready)
        inst_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      state_reg <= ST_REQ;
      hold_reg  <= 32'd0;
      pend_reg  <= 32'd0;
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (redirect) begin
            // Without a response the address must stay put, so park the target.
            if (imem_ready) begin
              pc_reg <= target;
            end else begin
              pend_reg  <= target;
              state_reg <= ST_DROP;
            end
          end else if (imem_ready) begin
            if (stall) begin
              hold_reg  <= imem_rdata;
              state_reg <= ST_HOLD;
            end else begin
              pc_reg <= pc_plus_4;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= ST_REQ;
          end else if (!stall) begin
            pc_reg    <= pc_plus_4;
            state_reg <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_ready) begin
            pc_reg    <= redirect ? target : pend_reg;
            state_reg <= ST_REQ;
          end else if (redirect) begin
            pend_reg <= target;
          end
        end
        default: state_reg <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall hold, redirect/drop,
// address wrap and reset priority.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc_plus_4;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .pc_plus_4(pc_plus_4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge; outputs are checked 1ns later.
  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rdata;
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Fetch-with-response cycle that expects a valid instruction.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic s);
    drive(0, s, 0, 0, 1, 32'hA000_0000 | addr);
    $display("fetch %s addr=%h inst=%h valid=%0b", tag, imem_addr, inst, inst_valid);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_inst"}, inst, 32'hA000_0000 | addr);
    chk({tag, "_pp4"}, pc_plus_4, addr + 32'd4);
    next();
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset with every other input active
    drive(1, 1, 1, 32'h40, 1, 32'h1);
    $display("reset req=%0b valid=%0b", imem_req, inst_valid);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    next();

    // Sequential fetch 0x0..0xC
    fetch("seq0", 32'h0, 0);
    fetch("seq4", 32'h4, 0);
    fetch("seq8", 32'h8, 1);   // stall asserted: capture into hold buffer

    // Held for two more stall cycles, memory idle with garbage on rdata
    for (int i = 0; i < 3; i++) begin
      drive(0, (i < 2), 0, 0, 0, 32'hDEAD_BEEF);
      $display("hold%0d req=%0b inst=%h pp4=%h", i, imem_req, inst, pc_plus_4);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h2008_0005 ^ 32'h2008_0005 ^ 32'hA000_0008);
      chk("hold_pp4", pc_plus_4, 32'hC);
      next();
    end
    fetch("seqC", 32'hC, 0);

    // Redirect while waiting at 0x10 -> DROP
    drive(0, 0, 1, 32'h40, 0, 0);
    $display("redir_wait addr=%h valid=%0b", imem_addr, inst_valid);
    chk("rw_addr", imem_addr, 32'h10);
    chk("rw_valid", {31'd0, inst_valid}, 32'd0);
    next();
    drive(0, 0, 0, 0, 0, 0);
    $display("drop0 addr=%h req=%0b", imem_addr, imem_req);
    chk("drop0_addr", imem_addr, 32'h10);
    chk("drop0_req", {31'd0, imem_req}, 32'd1);
    next();
    drive(0, 0, 0, 0, 1, 32'h1111_1111);
    $display("drop1 addr=%h valid=%0b", imem_addr, inst_valid);
    chk("drop1_addr", imem_addr, 32'h10);
    chk("drop1_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("tgt40", 32'h40, 0);

    // Latest redirect wins while in DROP
    drive(0, 0, 1, 32'h40, 0, 0);
    chk("lw_valid", {31'd0, inst_valid}, 32'd0);
    next();
    drive(0, 0, 1, 32'h80, 0, 0);
    $display("lw redirect addr=%h", imem_addr);
    chk("lw_addr", imem_addr, 32'h44);
    next();
    drive(0, 0, 0, 0, 1, 0);
    chk("lw_drop_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("tgt80", 32'h80, 0);

    // Unaligned redirect target, then a redirect coinciding with the late response
    drive(0, 0, 1, 32'h83, 0, 0);
    next();
    drive(0, 0, 0, 0, 1, 0);
    chk("ua_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("tgt80b", 32'h80, 0);
    drive(0, 0, 1, 32'h200, 0, 0);
    next();
    drive(0, 0, 1, 32'h100, 1, 0);
    chk("dr_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("tgt100", 32'h100, 0);

    // Redirect with a response in REQ, then wrap at the top of memory
    drive(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    chk("rr_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("wrap", 32'hFFFF_FFFC, 0);
    fetch("wrap0", 32'h0, 0);

    // Redirect out of HOLD
    fetch("h4", 32'h4, 1);
    drive(0, 1, 1, 32'h200, 0, 0);
    chk("hr_valid", {31'd0, inst_valid}, 32'd0);
    next();
    fetch("tgt200", 32'h200, 1);

    // Reset beats stall and redirect while in HOLD
    drive(1, 1, 1, 32'h300, 1, 0);
    $display("rst_hold req=%0b valid=%0b", imem_req, inst_valid);
    chk("rh_req", {31'd0, imem_req}, 32'd0);
    chk("rh_valid", {31'd0, inst_valid}, 32'd0);
    next();
    drive(0, 0, 0, 0, 0, 0);
    $display("post_rst addr=%h req=%0b pp4=%h", imem_addr, imem_req, pc_plus_4);
    chk("pr_addr", imem_addr, 32'h0);
    chk("pr_req", {31'd0, imem_req}, 32'd1);
    chk("pr_valid", {31'd0, inst_valid}, 32'd0);
    chk("pr_pp4", pc_plus_4, 32'h4);
    next();
    fetch("pr_fetch", 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stall  input  1  hazard unit says the IF/ID register is not loading this cycle.
REQ-005 redirect  input  1  branch/jump taken; fetch SHALL restart at redirect_pc.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  instruction-memory word address.
REQ-009 imem_ready  input  1  memory returns imem_rdata for the current request this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 inst_valid  output  1  inst/pc_plus_4 hold a valid instruction for IF/ID.
REQ-012 inst  output  32  fetched instruction, to IF/ID.
REQ-013 pc_plus_4  output  32  address of inst plus 4, to IF/ID.

Function
REQ-014 State: 32-bit pc, 32-bit hold buffer, 32-bit pending-target register, FSM {REQ, HOLD, DROP}.
REQ-015 imem_addr SHALL equal pc in every state; imem_req SHALL be 1 in REQ and DROP, 0 in HOLD and while rst=1.
REQ-016 Memory protocol: once imem_req=1, imem_addr SHALL stay stable until the cycle imem_ready=1; one request outstanding at most.
REQ-017 pc_plus_4 SHALL equal pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 REQ, imem_ready=0, redirect=0: hold, inst_valid=0.
REQ-019 REQ, imem_ready=1, redirect=0, stall=0: inst_valid=1, inst=imem_rdata same cycle (zero-cycle latency); next cycle pc<=pc+4, stay REQ.
REQ-020 REQ, imem_ready=1, redirect=0, stall=1: inst_valid=1, inst=imem_rdata; hold buffer<=imem_rdata; go HOLD.
REQ-021 HOLD: imem_req=0, inst_valid=1, inst=hold buffer; stall=1 stays HOLD; stall=0 -> pc<=pc+4, go REQ.
REQ-022 Redirect has top priority in every state and SHALL force inst_valid=0 in that cycle.
REQ-023 Redirect in REQ with imem_ready=1, or in HOLD: response discarded, pc<={redirect_pc[31:2],2'b00}, go REQ.
REQ-024 Redirect in REQ with imem_ready=0: pending-target<={redirect_pc[31:2],2'b00}, go DROP; pc unchanged so imem_addr stays stable.
REQ-025 DROP: inst_valid=0; each redirect overwrites pending-target (latest wins); imem_ready=1 -> response discarded, pc<=pending-target (or redirect_pc if redirect same cycle), go REQ.
REQ-026 stall SHALL never alter pc, the FSM, or the memory request except as in REQ-020/021.
REQ-027 inst and pc_plus_4 SHALL be don't-care when inst_valid=0; the bench SHALL not check them.

Reset
REQ-028 While rst=1: imem_req=0, inst_valid=0; next edge pc<=RESET_PC, FSM<=REQ, hold buffer<=0, pending-target<=0.
REQ-029 rst takes priority over redirect, stall and imem_ready; rst mid-request abandons it, and the memory SHALL not assert imem_ready for that request after reset.
REQ-030 First cycle after rst falls: imem_req=1, imem_addr=RESET_PC, pc_plus_4=RESET_PC+4.

Verification
REQ-031 Reset, imem_ready=1 always, stall=0 -> imem_addr 0x0,0x4,0x8,0xC on consecutive cycles, inst_valid=1 each, pc_plus_4 0x4,0x8,0xC,0x10.
REQ-032 Fetch at 0x8, imem_rdata=0x2008_0005, stall=1 for 3 cycles -> HOLD, inst=0x2008_0005 and pc_plus_4=0xC steady, imem_req=0; stall drop -> next imem_addr=0xC.
REQ-033 REQ at 0x10, imem_ready=0, redirect=1 redirect_pc=0x40 -> DROP, imem_addr stays 0x10; ready after 2 cycles -> discarded, inst_valid=0; next imem_addr=0x40.
REQ-034 In DROP, redirects to 0x40 then 0x80 before ready -> fetch resumes at 0x80; redirect_pc=0x83 -> fetch at 0x80.
REQ-035 pc=0xFFFF_FFFC, ready, stall=0 -> pc_plus_4=0x0, next imem_addr=0x0.
REQ-036 rst=1 in HOLD with stall=1 and redirect=1 -> next cycle imem_addr=RESET_PC, inst_valid=0, FSM REQ.
